// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage with a small prefetch queue.
//
// Owns the PC, addresses a combinational-read instruction memory, captures
// the returned word into a circular queue, and presents the head entry to
// decode with a valid/ready handshake. A redirect flushes the queue and
// reloads the PC.
//
// Ports:
//   clk, reset      system clock; synchronous active-high reset
//   imem_a          word address to imem (pc[ADDR_W+1:2])
//   imem_rd         instruction word from imem, same cycle
//   redirect_valid  flush the queue and load redirect_pc
//   redirect_pc     redirect target byte address
//   inst_valid      head entry valid
//   inst_ready      decode accepts the head this cycle
//   inst, inst_pc   head word and its byte address (0 when empty)
//   inst_pcplus4    inst_pc + 4 (0 when empty)
//   inst_fault      head entry came from a misaligned PC
//   q_count         occupied entries
//
// state | meaning
// FETCH | pushing one word per cycle whenever the queue has room
// HALT  | a misaligned-PC entry was queued; no pushes, pc held

module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 11,
    parameter int          DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        imem_a,
    input  logic [31:0]              imem_rd,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst,
    output logic [31:0]              inst_pc,
    output logic [31:0]              inst_pcplus4,
    output logic                     inst_fault,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     pc;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [31:0]     q_pc    [DEPTH];
    logic [31:0]     q_word  [DEPTH];
    logic            q_fault [DEPTH];
    logic            misaligned;
    logic            pop;
    logic            push;

    assign misaligned = (pc[1:0] != 2'b00);
    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready & ~redirect_valid;
    // A full queue may still accept a push when the head leaves this cycle.
    assign push       = (state == FETCH) & ~redirect_valid & ((count < FULL) | pop);

    assign imem_a       = pc[ADDR_W+1:2];
    assign q_count      = count;
    assign inst         = inst_valid ? q_word[head] : 32'h0;
    assign inst_pc      = inst_valid ? q_pc[head] : 32'h0;
    assign inst_pcplus4 = inst_valid ? (q_pc[head] + 32'd4) : 32'h0;
    assign inst_fault   = inst_valid & q_fault[head];

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            state_nxt = FETCH;
        end else if (push && misaligned) begin
            state_nxt = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
                pc   <= pc + 32'd4;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage has no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_pc[tail]    <= pc;
            q_word[tail]  <= misaligned ? 32'h0 : imem_rd;
            q_fault[tail] <= misaligned;
        end
    end

endmodule
